// File: rtl/anc_sample_sched.sv
// Per-sample scheduler: captures {e,x,a,u}, launches the ANC core, emits one output sample per input set.
// Latency: capture->out_valid is 2+k cycles (core done in RUN cycle k), 1 cycle in bypass, 2+TIMEOUT on watchdog.
// Backpressure: in_ready is high only in WAIT_IN; a new set is refused until the previous sample has been emitted.
module anc_sample_sched #(
    parameter int TIMEOUT = 1000,
    parameter int LAT_W   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_done,
    input  logic                    bypass_mode_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      e_in,
    input  logic signed [15:0]      x_in,
    input  logic signed [15:0]      a_in,
    input  logic signed [15:0]      u_in,
    output logic signed [15:0]      core_e,
    output logic signed [15:0]      core_x,
    output logic signed [15:0]      core_a,
    output logic signed [15:0]      core_u,
    output logic                    core_start,
    input  logic                    core_done,
    input  logic signed [15:0]      core_out,
    output logic signed [15:0]      out_sample,
    output logic                    out_valid,
    output logic [LAT_W-1:0]        max_lat,
    output logic [7:0]              timeout_cnt
);

    typedef enum logic [2:0] {IDLE, WAIT_IN, START, RUN, EMIT} state_t;

    localparam logic [LAT_W-1:0] TO_L = LAT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [LAT_W-1:0] timer;
    logic [LAT_W-1:0] lat_now;
    logic             cap, run_done, run_tmo;

    // lat_now is the RUN-cycle index of the current cycle (1 in the first RUN cycle)
    assign lat_now = timer + 1'b1;

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        cap        = 1'b0;
        run_done   = 1'b0;
        run_tmo    = 1'b0;
        case (state)
            IDLE: begin
                if (init_done) state_nxt = WAIT_IN;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cap       = 1'b1;
                    state_nxt = bypass_mode_sel ? EMIT : START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                if (core_done) begin
                    run_done  = 1'b1;
                    state_nxt = EMIT;
                end else if (lat_now == TO_L) begin
                    run_tmo   = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                state_nxt = WAIT_IN;
            end
            default: state_nxt = IDLE;
        endcase
        // Losing init_done kills the in-flight sample with no side effects
        if (!init_done) begin
            state_nxt  = IDLE;
            in_ready   = 1'b0;
            core_start = 1'b0;
            out_valid  = 1'b0;
            cap        = 1'b0;
            run_done   = 1'b0;
            run_tmo    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            core_e      <= '0;
            core_x      <= '0;
            core_a      <= '0;
            core_u      <= '0;
            out_sample  <= '0;
            max_lat     <= '0;
            timeout_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cap) begin
                core_e <= e_in;
                core_x <= x_in;
                core_a <= a_in;
                core_u <= u_in;
                if (bypass_mode_sel) out_sample <= a_in;
            end
            if (core_start)        timer <= '0;
            else if (state == RUN) timer <= lat_now;
            if (run_done) begin
                out_sample <= core_out;
                if (lat_now > max_lat) max_lat <= lat_now;
            end
            if (run_tmo) begin
                out_sample <= '0;
                if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_anc_sample_sched.sv
// Directed bench for anc_sample_sched: stimulus pushes expected {sample, cycle} into a scoreboard,
// a negedge monitor pops and compares on every out_valid.
`timescale 1ns/1ps
module tb_anc_sample_sched;

    localparam int TO    = 8;
    localparam int LAT_W = 10;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               init_done = 1'b0;
    logic               bypass_mode_sel = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        e_in = '0, x_in = '0, a_in = '0, u_in = '0;
    logic [15:0]        core_e, core_x, core_a, core_u;
    logic               core_start;
    logic               core_done = 1'b0;
    logic [15:0]        core_out = '0;
    logic [15:0]        out_sample;
    logic               out_valid;
    logic [LAT_W-1:0]   max_lat;
    logic [7:0]         timeout_cnt;

    anc_sample_sched #(.TIMEOUT(TO), .LAT_W(LAT_W)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .bypass_mode_sel(bypass_mode_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .e_in(e_in), .x_in(x_in), .a_in(a_in), .u_in(u_in),
        .core_e(core_e), .core_x(core_x), .core_a(core_a), .core_u(core_u),
        .core_start(core_start), .core_done(core_done), .core_out(core_out),
        .out_sample(out_sample), .out_valid(out_valid),
        .max_lat(max_lat), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] smp;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (core_start) start_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid: got out_sample=%h want no pulse (cycle %0d)", out_sample, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_sample", out_sample, mon_e.smp);
                    check("out_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    // Presents one set; the expectation is queued before the capture edge so the monitor never races it
    task automatic capture(input logic [15:0] e, input logic [15:0] x, input logic [15:0] a,
                           input logic [15:0] u, input logic byp, input logic push,
                           input logic [15:0] smp, input int lat);
        exp_t t;
        wait_ready();
        e_in = e; x_in = x; a_in = a; u_in = u;
        bypass_mode_sel = byp;
        in_valid = 1'b1;
        if (push) begin
            t.smp = smp;
            t.at  = cyc + lat;
            sb.push_back(t);
        end
        @(negedge clk);
        in_valid = 1'b0;
        bypass_mode_sel = 1'b0;
    endtask

    // k = RUN cycle on which core_done is returned; 0 means never
    task automatic send(input logic [15:0] e, input logic [15:0] x, input logic [15:0] a,
                        input logic [15:0] u, input logic byp, input int k, input logic [15:0] cv);
        logic [15:0] smp;
        int          lat;
        if (byp) begin
            smp = a;  lat = 1;
        end else if (k > 0 && k <= TO) begin
            smp = cv; lat = 2 + k;
        end else begin
            smp = 16'h0; lat = 2 + TO;
        end
        capture(e, x, a, u, byp, 1'b1, smp, lat);
        if (!byp) begin
            check("core_start_pulse", core_start, 1);
            check("in_ready_low", in_ready, 0);
            check("core_x", core_x, x);
            check("core_a", core_a, a);
            if (k > 0) begin
                repeat (k) @(negedge clk);
                core_out  = cv;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    endtask

    initial begin
        int s;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sample", out_sample, 0);
        check("rst_core_x", core_x, 0);
        check("rst_max_lat", max_lat, 0);
        check("rst_timeout_cnt", timeout_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_ready", in_ready, 0);
        init_done = 1'b1;

        // normal path, done on RUN cycle 5
        send(16'h0100, 16'hFF00, 16'h1234, 16'h0010, 1'b0, 5, 16'h7FFF);
        wait_ready();
        check("normal_max_lat", max_lat, 5);
        check("normal_core_e", core_e, 16'h0100);

        // bypass never touches the core
        s = start_cnt;
        send(16'h0001, 16'h0002, 16'h8001, 16'h0003, 1'b1, 0, 16'h0);
        wait_ready();
        check("bypass_no_start", start_cnt, s);

        // watchdog
        send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 0, 16'h0);
        wait_ready();
        check("wdog_cnt1", timeout_cnt, 1);

        // done and timeout on the same cycle: done wins
        send(16'h0005, 16'h0006, 16'h0007, 16'h0008, 1'b0, TO, 16'h0042);
        wait_ready();
        check("simul_cnt", timeout_cnt, 1);
        check("simul_max_lat", max_lat, 8);

        for (int i = 0; i < 300; i++) begin
            send(16'(i), 16'(i + 1), 16'(i + 2), 16'(i + 3), 1'b0, 0, 16'h0);
        end
        wait_ready();
        check("wdog_saturate", timeout_cnt, 255);

        // spurious done while waiting for input
        core_out  = 16'h5555;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("spur_out_sample", out_sample, 0);
        check("spur_max_lat", max_lat, 8);
        check("spur_still_ready", in_ready, 1);
        send(16'h000A, 16'h000B, 16'h000C, 16'h000D, 1'b0, 3, 16'h0101);
        wait_ready();
        check("spur_max_lat_after", max_lat, 8);

        // init_done dropped during RUN
        capture(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 1'b0, 1'b0, 16'h0, 0);
        repeat (2) @(negedge clk);
        init_done = 1'b0;
        repeat (TO + 4) @(negedge clk);
        check("init_gate_ready", in_ready, 0);
        check("init_gate_cnt", timeout_cnt, 255);
        init_done = 1'b1;
        send(16'h0F0F, 16'h0E0E, 16'h0D0D, 16'h0C0C, 1'b0, 2, 16'h0202);
        wait_ready();

        // reset mid-RUN after a max_lat=5 sample
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0100, 16'hFF00, 16'h1234, 16'h0010, 1'b0, 5, 16'h0303);
        wait_ready();
        check("pre_rst_max_lat", max_lat, 5);
        capture(16'h7777, 16'h6666, 16'h5555, 16'h4444, 1'b0, 1'b0, 16'h0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_max_lat", max_lat, 0);
        check("mid_rst_out_sample", out_sample, 0);
        check("mid_rst_core_x", core_x, 0);
        check("mid_rst_core_start", core_start, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_timeout_cnt", timeout_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 1'b0, 4, 16'h1111);
        wait_ready();
        check("post_rst_max_lat", max_lat, 4);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish by 500us");
        $fatal(1, "simulation time limit");
    end

endmodule
